// File: rtl/cfg_frame_loader.sv
// cfg_frame_loader: byte-stream configuration frame loader for the CGRA fabric.
// Assembles FRAME_BITS-wide frames from a valid/ready byte stream, drives each
// frame onto the shared latch data bus, then pulses one row strobe with a setup
// cycle before and a hold cycle after it.
// Optional feature macro: CFG_CRC_EN (adds a CRC-8 check byte after the data bytes).
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | wait for a command byte (0xA5 write, 0x5A end)
// S_ADDR   | capture frame address byte
// S_DATA   | collect NB data bytes, LSB first
// S_CRC    | (CFG_CRC_EN only) compare the received CRC-8 byte
// S_SETUP  | frame_data driven and settling, strobes low
// S_STROBE | selected row strobe high for one cycle
// S_HOLD   | strobes low, frame_data still held
// S_DONE   | end command seen, terminal until reset
module cfg_frame_loader #(
    parameter int FRAME_BITS = 32,
    parameter int NUM_FRAMES = 16,
    parameter int ADDR_BITS  = 4
) (
    input  logic                  clk,
    input  logic                  rn,
    input  logic [7:0]            cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic [NUM_FRAMES-1:0] frame_strobe,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int NB = FRAME_BITS / 8;
    localparam int CW = $clog2(NB + 1);
    localparam logic [7:0] CMD_WRITE = 8'hA5;
    localparam logic [7:0] CMD_END   = 8'h5A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
`ifdef CFG_CRC_EN
        S_CRC,
`endif
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [ADDR_BITS-1:0]  r_addr;
    logic                  r_addr_bad;
    logic [CW-1:0]         r_cnt;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRAME_BITS-1:0] r_frame;
    logic [NUM_FRAMES-1:0] r_strobe;
    logic                  r_done;
    logic                  r_err;
`ifdef CFG_CRC_EN
    logic [7:0]            r_crc;
`endif

    logic                  w_ready_state;
    logic                  w_take;
    logic                  w_last;
    logic [FRAME_BITS-1:0] w_frame;
    logic [NUM_FRAMES-1:0] w_onehot;

`ifdef CFG_CRC_EN
    // CRC-8, polynomial 0x07, MSB first, one byte per call
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int i = 0; i < 8; i++) begin
            x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        end
        return x;
    endfunction
`endif

    // Ready depends only on state; gated by reset so every output reads 0 in reset
    always_comb begin
        w_ready_state = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_DATA);
`ifdef CFG_CRC_EN
        if (r_state == S_CRC) w_ready_state = 1'b1;
`endif
    end

    assign cfg_ready = w_ready_state & rn;
    assign w_take    = cfg_valid & w_ready_state;
    assign w_last    = (r_cnt == CW'(NB - 1));
    assign w_onehot  = NUM_FRAMES'(1) << r_addr;

    // Shift register image including the byte being accepted this cycle
    always_comb begin
        w_frame = r_shift;
        w_frame[{r_cnt, 3'b000} +: 8] = cfg_data;
    end

    // Main sequencer; strobe defaults low so it can only be high in S_STROBE
    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_addr_bad <= 1'b0;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_frame    <= '0;
            r_strobe   <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef CFG_CRC_EN
            r_crc      <= '0;
`endif
        end else begin
            r_strobe <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        if (cfg_data == CMD_WRITE) begin
                            r_state <= S_ADDR;
                        end else if (cfg_data == CMD_END) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    if (w_take) begin
                        r_addr     <= cfg_data[ADDR_BITS-1:0];
                        r_addr_bad <= (32'(cfg_data) >= NUM_FRAMES);
                        r_cnt      <= '0;
`ifdef CFG_CRC_EN
                        r_crc      <= crc8_step(8'h00, cfg_data);
`endif
                        r_state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_take) begin
                        r_shift <= w_frame;
                        r_cnt   <= r_cnt + CW'(1);
`ifdef CFG_CRC_EN
                        r_crc   <= crc8_step(r_crc, cfg_data);
                        if (w_last) r_state <= S_CRC;
`else
                        if (w_last) begin
                            if (!r_addr_bad) begin
                                r_frame <= w_frame;
                                r_state <= S_SETUP;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        end
`endif
                    end
                end
`ifdef CFG_CRC_EN
                S_CRC: begin
                    if (w_take) begin
                        if (!r_addr_bad && (cfg_data == r_crc)) begin
                            r_frame <= r_shift;
                            r_state <= S_SETUP;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
`endif
                S_SETUP: begin
                    r_strobe <= w_onehot;
                    r_state  <= S_STROBE;
                end
                S_STROBE: r_state <= S_HOLD;
                S_HOLD:   r_state <= S_IDLE;
                S_DONE:   r_state <= S_DONE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign busy         = (r_state != S_IDLE) && (r_state != S_DONE);
    assign frame_data   = r_frame;
    assign frame_strobe = r_strobe;
    assign done         = r_done;
    assign err          = r_err;

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Self-checking bench for cfg_frame_loader: stream-level reference model plus
// per-cycle comparison and directed scenarios with literal expectations.
module tb_cfg_frame_loader;

    localparam int FB = 32;
    localparam int NF = 16;
    localparam int AB = 4;
    localparam int NB = FB / 8;

    logic          clk = 1'b0;
    logic          rn = 1'b0;
    logic [7:0]    cfg_data = 8'h00;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [FB-1:0] frame_data;
    logic [NF-1:0] frame_strobe;
    logic          busy;
    logic          done;
    logic          err;

    cfg_frame_loader #(.FRAME_BITS(FB), .NUM_FRAMES(NF), .ADDR_BITS(AB)) dut (
        .clk          (clk),
        .rn           (rn),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .frame_data   (frame_data),
        .frame_strobe (frame_strobe),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        return x;
    endfunction

    // ---------------- stream-level reference model ----------------
    // m_pos: 0 expect command, 1 expect address, 2 expect data, 3 expect CRC
    int          cyc = 0;
    int          m_pos = 0;
    int          m_k = 0;
    int          m_free = 0;
    int          m_strobe_edge = -100;
    logic [7:0]  m_abyte = 8'h00;
    logic [31:0] m_buf = '0;
    logic [31:0] m_fd = '0;
    logic [7:0]  m_crc = 8'h00;
    bit          m_done = 1'b0;
    bit          m_err = 1'b0;

    // A complete frame accepted on edge e: data appears at e, strobe after e+1,
    // bus released (ready) for the edge e+4.
    task automatic m_finish(input int e);
        m_pos = 0;
        if (m_abyte < NF) begin
            m_fd          = m_buf;
            m_strobe_edge = e + 1;
            m_free        = e + 4;
        end else begin
            m_err = 1'b1;
        end
    endtask

    always @(posedge clk or negedge rn) begin
        if (!rn) begin
            m_pos = 0; m_k = 0; m_free = 0; m_strobe_edge = -100;
            m_fd = '0; m_buf = '0; m_done = 1'b0; m_err = 1'b0;
        end else begin
            int e;
            e = cyc + 1;
            if (cfg_valid && !m_done && e >= m_free) begin
                case (m_pos)
                    0: begin
                        if (cfg_data == 8'hA5) m_pos = 1;
                        else if (cfg_data == 8'h5A) m_done = 1'b1;
                        else m_err = 1'b1;
                    end
                    1: begin
                        m_abyte = cfg_data;
                        m_crc   = crc8(8'h00, cfg_data);
                        m_buf   = '0;
                        m_k     = 0;
                        m_pos   = 2;
                    end
                    2: begin
                        m_buf[8*m_k +: 8] = cfg_data;
                        m_crc = crc8(m_crc, cfg_data);
                        m_k++;
                        if (m_k == NB) begin
`ifdef CFG_CRC_EN
                            m_pos = 3;
`else
                            m_finish(e);
`endif
                        end
                    end
                    default: begin
                        if (cfg_data == m_crc) m_finish(e);
                        else begin m_err = 1'b1; m_pos = 0; end
                    end
                endcase
            end
            cyc = e;
        end
    end

    // ---------------- per-cycle comparison ----------------
    int          n_strobe = 0;
    logic [15:0] last_strobe = '0;
    logic [31:0] prev_fd = '0;

    always @(negedge clk) begin
        if (!rn) begin
            chk("rst_ready",  64'(cfg_ready), 64'(0));
            chk("rst_busy",   64'(busy), 64'(0));
            chk("rst_strobe", 64'(frame_strobe), 64'(0));
            chk("rst_data",   64'(frame_data), 64'(0));
            chk("rst_flags",  64'({done, err}), 64'(0));
        end else begin
            bit          e_ready;
            bit          e_busy;
            logic [15:0] e_strobe;
            e_ready  = !m_done && (cyc + 1 >= m_free);
            e_busy   = !m_done && ((m_pos != 0) || !(cyc + 1 >= m_free));
            e_strobe = (cyc == m_strobe_edge) ? (16'(1) << m_abyte[3:0]) : 16'h0000;
            chk("ready",  64'(cfg_ready), 64'(e_ready));
            chk("busy",   64'(busy), 64'(e_busy));
            chk("strobe", 64'(frame_strobe), 64'(e_strobe));
            chk("data",   64'(frame_data), 64'(m_fd));
            chk("done",   64'(done), 64'(m_done));
            chk("err",    64'(err), 64'(m_err));
        end
        chk("onehot0", 64'($onehot0(frame_strobe)), 64'(1));
        if (frame_strobe != '0) begin
            chk("data_stable_under_strobe", 64'(frame_data), 64'(prev_fd));
            n_strobe++;
            last_strobe = frame_strobe;
        end
        prev_fd = frame_data;
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b);
        int t;
        cfg_data  = b;
        cfg_valid = 1'b1;
        t = 0;
        while (!cfg_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("send_timeout", 64'(0), 64'(1));
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [31:0] d);
        send(8'hA5);
        send(a);
        for (int i = 0; i < NB; i++) send(d[8*i +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        #1;
        chk("reset_ready", 64'(cfg_ready), 64'(0));
        chk("reset_outs",  64'({busy, done, err, frame_strobe}), 64'(0));
        #11 rn = 1'b1;
        @(negedge clk);

        // 1: frame DEADBEEF to row 3, timing pinned by hand
        send_frame(8'h03, 32'hDEADBEEF);
        chk("t1_setup_data",   64'(frame_data), 64'h0000_0000_DEAD_BEEF);
        chk("t1_setup_strobe", 64'(frame_strobe), 64'(0));
        chk("t1_setup_ready",  64'(cfg_ready), 64'(0));
        @(negedge clk);
        chk("t1_strobe",       64'(frame_strobe), 64'h0008);
        chk("t1_strobe_ready", 64'(cfg_ready), 64'(0));
        @(negedge clk);
        chk("t1_hold_strobe",  64'(frame_strobe), 64'(0));
        chk("t1_hold_data",    64'(frame_data), 64'h0000_0000_DEAD_BEEF);
        chk("t1_hold_ready",   64'(cfg_ready), 64'(0));
        @(negedge clk);
        chk("t1_ready_back",   64'(cfg_ready), 64'(1));
        chk("t1_model_fd",     64'(m_fd), 64'h0000_0000_DEAD_BEEF);
        // back-to-back frame to the highest row
        send_frame(8'h0F, 32'h12345678);
        idle(5);
        chk("t1b_data",   64'(frame_data), 64'h0000_0000_1234_5678);
        chk("t1b_strobe", 64'(last_strobe), 64'h8000);
        chk("t1b_count",  64'(n_strobe), 64'(2));
        chk("t1b_err",    64'(err), 64'(0));

        // 3: illegal command, then a normal frame to row 0
        send(8'h00);
        chk("t3_err",  64'(err), 64'(1));
        chk("t3_busy", 64'(busy), 64'(0));
        send_frame(8'h00, 32'hDDCCBBAA);
        idle(5);
        chk("t3_data",   64'(frame_data), 64'h0000_0000_DDCC_BBAA);
        chk("t3_strobe", 64'(last_strobe), 64'h0001);

        // 2: out-of-range address 20
        snap = n_strobe;
        send_frame(8'h14, 32'h44332211);
        idle(4);
        chk("t2_err",   64'(err), 64'(1));
        chk("t2_count", 64'(n_strobe), 64'(snap));
        chk("t2_data",  64'(frame_data), 64'h0000_0000_DDCC_BBAA);

        // 4: reset mid-frame
        snap = n_strobe;
        send(8'hA5); send(8'h05); send(8'h01); send(8'h02);
        #2 rn = 1'b0;
        #1;
        chk("t4_async_data",  64'(frame_data), 64'(0));
        chk("t4_async_flags", 64'({cfg_ready, busy, done, err, frame_strobe}), 64'(0));
        @(posedge clk);
        @(negedge clk);
        #2 rn = 1'b1;
        @(negedge clk);
        chk("t4_no_strobe", 64'(n_strobe), 64'(snap));
        send_frame(8'h05, 32'h04030201);
        idle(5);
        chk("t4_data",   64'(frame_data), 64'h0000_0000_0403_0201);
        chk("t4_strobe", 64'(last_strobe), 64'h0020);
        chk("t4_err",    64'(err), 64'(0));

`ifdef CFG_CRC_EN
        // 6: CRC good then corrupted
        chk("t6_crc_model", 64'(crc8(crc8(crc8(crc8(crc8(8'h00, 8'h01), 8'h00), 8'h00), 8'h00), 8'h00)), 64'h62);
        send_frame(8'h01, 32'h00000000);
        send(8'h62);
        idle(5);
        chk("t6_strobe", 64'(last_strobe), 64'h0002);
        chk("t6_data",   64'(frame_data), 64'(0));
        chk("t6_err",    64'(err), 64'(0));
        snap = n_strobe;
        send_frame(8'h01, 32'h00000000);
        send(8'h63);
        idle(5);
        chk("t6_bad_err",   64'(err), 64'(1));
        chk("t6_bad_count", 64'(n_strobe), 64'(snap));
`endif

        // 5: end command, then a stalled stream must not be accepted
        snap = n_strobe;
        send(8'h5A);
        chk("t5_done",  64'(done), 64'(1));
        chk("t5_busy",  64'(busy), 64'(0));
        chk("t5_ready", 64'(cfg_ready), 64'(0));
        cfg_data  = 8'hA5;
        cfg_valid = 1'b1;
        idle(10);
        cfg_valid = 1'b0;
        idle(2);
        chk("t5_still_done", 64'(done), 64'(1));
        chk("t5_ready_off",  64'(cfg_ready), 64'(0));
        chk("t5_no_strobe",  64'(n_strobe), 64'(snap));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
